// File: rtl/execute_stage.sv
// Execute stage of the 16-bit five-stage pipeline: operand forwarding, ALU, branch
// resolution, wrong-path squash and sticky halt, all feeding the EX/MEM register.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [15:0] A_IDEX,
    input  logic [15:0] B_IDEX,
    input  logic [15:0] Imm_IDEX,
    input  logic [15:0] PCinc_IDEX,
    input  logic [15:0] BrTarget_IDEX,
    input  logic [2:0]  Rs_IDEX,
    input  logic [2:0]  Rt_IDEX,
    input  logic        UseRs_IDEX,
    input  logic        UseRt_IDEX,
    input  logic        ImmSel_IDEX,
    input  logic        LinkSel_IDEX,
    input  logic [3:0]  ALUOp_IDEX,
    input  logic [2:0]  BrType_IDEX,
    input  logic        MemWrite_IDEX,
    input  logic        MemRead_IDEX,
    input  logic        MemtoReg_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic        Dump_IDEX,
    input  logic        halt_IDEX,
    input  logic [2:0]  WrR_IDEX,
    output logic [15:0] ALUO_EXMEM,
    output logic [15:0] Rd2_EXMEM,
    output logic [15:0] BrTarget_EXMEM,
    output logic        takeBranch,
    output logic        takeBranch_EXMEM,
    output logic        MemWrite_EXMEM,
    output logic        MemRead_EXMEM,
    output logic        MemtoReg_EXMEM,
    output logic        RegWrite_EXMEM,
    output logic        Dump_EXMEM,
    output logic        halt_EXMEM,
    output logic [2:0]  WrR_EXMEM,
    input  logic        RegWrite_MEMWB,
    input  logic [2:0]  WrR_MEMWB,
    input  logic [15:0] WbData
);

    typedef enum logic {NORMAL = 1'b0, SQUASH = 1'b1} state_t;

    state_t      r_state;
    logic        r_halted;

    logic        w_squash;
    logic        w_kill;
    logic        w_fwd_a_ex, w_fwd_a_wb, w_fwd_b_ex, w_fwd_b_wb;
    logic [15:0] w_a, w_b_fwd, w_b;
    logic [16:0] w_sum;
    logic [31:0] w_rol_t, w_ror_t;
    logic [15:0] w_brev;
    logic [15:0] w_alu;
    logic [15:0] w_result;
    logic        w_br_cond;

    assign w_squash = (r_state == SQUASH);
    // Squashed wrong-path instructions and anything after a halt must not touch state.
    assign w_kill   = w_squash | r_halted;

    // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet, so it never forwards.
    assign w_fwd_a_ex = RegWrite_EXMEM & ~MemtoReg_EXMEM & (WrR_EXMEM == Rs_IDEX) & UseRs_IDEX;
    assign w_fwd_a_wb = RegWrite_MEMWB & (WrR_MEMWB == Rs_IDEX) & UseRs_IDEX;
    assign w_fwd_b_ex = RegWrite_EXMEM & ~MemtoReg_EXMEM & (WrR_EXMEM == Rt_IDEX) & UseRt_IDEX;
    assign w_fwd_b_wb = RegWrite_MEMWB & (WrR_MEMWB == Rt_IDEX) & UseRt_IDEX;

    assign w_a     = w_fwd_a_ex ? ALUO_EXMEM : (w_fwd_a_wb ? WbData : A_IDEX);
    assign w_b_fwd = w_fwd_b_ex ? ALUO_EXMEM : (w_fwd_b_wb ? WbData : B_IDEX);
    assign w_b     = ImmSel_IDEX ? Imm_IDEX : w_b_fwd;

    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_rol_t = {w_a, w_a} << w_b[3:0];
    assign w_ror_t = {w_a, w_a} >> w_b[3:0];

    always_comb begin
        w_brev = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            w_brev[i] = w_a[15-i];
        end
    end

    always_comb begin
        w_alu = 16'h0000;
        case (ALUOp_IDEX)
            4'd0:    w_alu = w_sum[15:0];
            4'd1:    w_alu = w_b - w_a;
            4'd2:    w_alu = w_a ^ w_b;
            4'd3:    w_alu = w_a & ~w_b;
            4'd4:    w_alu = w_rol_t[31:16];
            4'd5:    w_alu = w_a << w_b[3:0];
            4'd6:    w_alu = w_ror_t[15:0];
            4'd7:    w_alu = w_a >> w_b[3:0];
            4'd8:    w_alu = {15'd0, (w_a == w_b)};
            4'd9:    w_alu = {15'd0, ($signed(w_a) < $signed(w_b))};
            4'd10:   w_alu = {15'd0, ($signed(w_a) <= $signed(w_b))};
            4'd11:   w_alu = {15'd0, w_sum[16]};
            4'd12:   w_alu = w_brev;
            4'd13:   w_alu = w_b;
            default: w_alu = 16'h0000;
        endcase
    end

    assign w_result = LinkSel_IDEX ? PCinc_IDEX : w_alu;

    always_comb begin
        w_br_cond = 1'b0;
        case (BrType_IDEX)
            3'd1:    w_br_cond = (w_a == 16'h0000);
            3'd2:    w_br_cond = (w_a != 16'h0000);
            3'd3:    w_br_cond = w_a[15];
            3'd4:    w_br_cond = ~w_a[15];
            3'd5:    w_br_cond = 1'b1;
            default: w_br_cond = 1'b0;
        endcase
    end

    assign takeBranch = w_br_cond & ~w_squash & ~r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= NORMAL;
            r_halted         <= 1'b0;
            ALUO_EXMEM       <= 16'h0000;
            Rd2_EXMEM        <= 16'h0000;
            BrTarget_EXMEM   <= 16'h0000;
            WrR_EXMEM        <= 3'd0;
            takeBranch_EXMEM <= 1'b0;
            MemWrite_EXMEM   <= 1'b0;
            MemRead_EXMEM    <= 1'b0;
            MemtoReg_EXMEM   <= 1'b0;
            RegWrite_EXMEM   <= 1'b0;
            Dump_EXMEM       <= 1'b0;
            halt_EXMEM       <= 1'b0;
        end else if (freeze) begin
            ALUO_EXMEM       <= w_result;
            Rd2_EXMEM        <= w_b_fwd;
            BrTarget_EXMEM   <= BrTarget_IDEX;
            WrR_EXMEM        <= WrR_IDEX;
            takeBranch_EXMEM <= takeBranch;
            MemWrite_EXMEM   <= MemWrite_IDEX & ~w_kill;
            MemRead_EXMEM    <= MemRead_IDEX & ~w_kill;
            MemtoReg_EXMEM   <= MemtoReg_IDEX & ~w_kill;
            RegWrite_EXMEM   <= RegWrite_IDEX & ~w_kill;
            Dump_EXMEM       <= Dump_IDEX & ~w_kill;
            halt_EXMEM       <= r_halted | (halt_IDEX & ~w_squash);
            if (halt_IDEX & ~w_squash) begin
                r_halted <= 1'b1;
            end
            case (r_state)
                NORMAL:  if (takeBranch) r_state <= SQUASH;
                SQUASH:  r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared one clock later.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [15:0] A_IDEX, B_IDEX, Imm_IDEX, PCinc_IDEX, BrTarget_IDEX;
  logic [2:0]  Rs_IDEX, Rt_IDEX, WrR_IDEX, BrType_IDEX, WrR_MEMWB;
  logic        UseRs_IDEX, UseRt_IDEX, ImmSel_IDEX, LinkSel_IDEX;
  logic [3:0]  ALUOp_IDEX;
  logic        MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX;
  logic        RegWrite_MEMWB;
  logic [15:0] WbData;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, BrTarget_EXMEM;
  logic        takeBranch, takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM;
  logic        RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM;
  logic [2:0]  WrR_EXMEM;

  logic [57:0] act;
  logic [57:0] exp_q[$];
  logic [57:0] last_exp;
  int          checks = 0;
  int          errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .A_IDEX(A_IDEX), .B_IDEX(B_IDEX), .Imm_IDEX(Imm_IDEX), .PCinc_IDEX(PCinc_IDEX),
    .BrTarget_IDEX(BrTarget_IDEX), .Rs_IDEX(Rs_IDEX), .Rt_IDEX(Rt_IDEX),
    .UseRs_IDEX(UseRs_IDEX), .UseRt_IDEX(UseRt_IDEX), .ImmSel_IDEX(ImmSel_IDEX),
    .LinkSel_IDEX(LinkSel_IDEX), .ALUOp_IDEX(ALUOp_IDEX), .BrType_IDEX(BrType_IDEX),
    .MemWrite_IDEX(MemWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .Dump_IDEX(Dump_IDEX), .halt_IDEX(halt_IDEX),
    .WrR_IDEX(WrR_IDEX), .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM),
    .BrTarget_EXMEM(BrTarget_EXMEM), .takeBranch(takeBranch), .takeBranch_EXMEM(takeBranch_EXMEM),
    .MemWrite_EXMEM(MemWrite_EXMEM), .MemRead_EXMEM(MemRead_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM),
    .WrR_EXMEM(WrR_EXMEM), .RegWrite_MEMWB(RegWrite_MEMWB), .WrR_MEMWB(WrR_MEMWB), .WbData(WbData)
  );

  always #5 clk = ~clk;

  assign act = {ALUO_EXMEM, Rd2_EXMEM, BrTarget_EXMEM, takeBranch_EXMEM, MemWrite_EXMEM,
                MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM, WrR_EXMEM};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent reference ALU (rotations and reversal done bit by bit).
  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] r;
    logic [16:0] s;
    r = 16'h0000;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd0: r = a + b;
      4'd1: r = b - a;
      4'd2: r = a ^ b;
      4'd3: r = a & ~b;
      4'd4: begin r = a; for (int k = 0; k < int'(b[3:0]); k++) r = {r[14:0], r[15]}; end
      4'd5: r = a << b[3:0];
      4'd6: begin r = a; for (int k = 0; k < int'(b[3:0]); k++) r = {r[0], r[15:1]}; end
      4'd7: r = a >> b[3:0];
      4'd8: r = (a == b) ? 16'h1 : 16'h0;
      4'd9: r = ($signed(a) < $signed(b)) ? 16'h1 : 16'h0;
      4'd10: r = ($signed(a) <= $signed(b)) ? 16'h1 : 16'h0;
      4'd11: r = s[16] ? 16'h1 : 16'h0;
      4'd12: for (int k = 0; k < 16; k++) r[k] = a[15-k];
      4'd13: r = b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic clr();
    freeze = 1'b1;
    A_IDEX = '0; B_IDEX = '0; Imm_IDEX = '0; PCinc_IDEX = '0; BrTarget_IDEX = '0;
    Rs_IDEX = '0; Rt_IDEX = '0; WrR_IDEX = '0; BrType_IDEX = '0; ALUOp_IDEX = '0;
    UseRs_IDEX = 0; UseRt_IDEX = 0; ImmSel_IDEX = 0; LinkSel_IDEX = 0;
    MemWrite_IDEX = 0; MemRead_IDEX = 0; MemtoReg_IDEX = 0; RegWrite_IDEX = 0;
    Dump_IDEX = 0; halt_IDEX = 0;
    RegWrite_MEMWB = 0; WrR_MEMWB = '0; WbData = '0;
  endtask

  // Control order: tb, mw, mr, mtr, rw, dump, halt.
  task automatic push_exp(input logic [15:0] aluo, input logic [15:0] rd2, input logic [6:0] ctl);
    exp_q.push_back({aluo, rd2, BrTarget_IDEX, ctl, WrR_IDEX});
  endtask

  task automatic tick(input string tag);
    logic [57:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      chk(tag, {6'd0, act}, {6'd0, e});
    end
  endtask

  logic [15:0] br_a[6]    = '{16'h0000, 16'h0003, 16'h8000, 16'h8000, 16'h0000, 16'h0000};
  logic [2:0]  br_t[6]    = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6};
  logic        br_e[6]    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [15:0] ra, rb;
    clr();
    freeze = 1'b0;
    rst = 1'b1;
    #12;
    chk("reset_exmem", {6'd0, act}, 64'd0);
    chk("reset_tb", {63'd0, takeBranch}, 64'd0);
    rst = 1'b0;

    // ADD overflow wraps
    clr(); A_IDEX = 16'h7FFF; Imm_IDEX = 16'h0001; ImmSel_IDEX = 1; B_IDEX = 16'h1234;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd3;
    push_exp(16'h8000, 16'h1234, 7'b0000100); tick("add_ovf");

    // EX/MEM = 5 to r2, then EX/MEM beats MEM/WB
    clr(); A_IDEX = 16'h0005; RegWrite_IDEX = 1; WrR_IDEX = 3'd2;
    push_exp(16'h0005, 16'h0000, 7'b0000100); tick("load_r2");
    clr(); RegWrite_MEMWB = 1; WrR_MEMWB = 3'd2; WbData = 16'h0009;
    Rs_IDEX = 3'd2; UseRs_IDEX = 1; A_IDEX = 16'h00AA; B_IDEX = 16'h0007; ALUOp_IDEX = 4'd1;
    push_exp(16'h0002, 16'h0007, 7'b0000000); tick("fwd_exmem_wins");

    // MEM/WB forward on Rt, Rd2 takes the forwarded value
    clr(); RegWrite_MEMWB = 1; WrR_MEMWB = 3'd2; WbData = 16'h0009;
    Rt_IDEX = 3'd2; UseRt_IDEX = 1; B_IDEX = 16'h1111; A_IDEX = 16'h00F0; ALUOp_IDEX = 4'd2;
    MemWrite_IDEX = 1;
    push_exp(16'h00F9, 16'h0009, 7'b0100000); tick("fwd_memwb_rt");

    // A load in EX/MEM must not forward
    clr(); A_IDEX = 16'h0100; RegWrite_IDEX = 1; MemtoReg_IDEX = 1; MemRead_IDEX = 1; WrR_IDEX = 3'd4;
    push_exp(16'h0100, 16'h0000, 7'b0011100); tick("load_instr");
    clr(); Rs_IDEX = 3'd4; UseRs_IDEX = 1; A_IDEX = 16'h0003; B_IDEX = 16'h0001;
    push_exp(16'h0004, 16'h0001, 7'b0000000); tick("no_fwd_from_load");

    // BEQZ on forwarded zero, then squashed store
    clr(); RegWrite_IDEX = 1; WrR_IDEX = 3'd5;
    push_exp(16'h0000, 16'h0000, 7'b0000100); tick("load_r5_zero");
    clr(); Rs_IDEX = 3'd5; UseRs_IDEX = 1; A_IDEX = 16'h0077; BrType_IDEX = 3'd1;
    BrTarget_IDEX = 16'h0040; PCinc_IDEX = 16'h0012;
    #1 chk("beqz_taken", {63'd0, takeBranch}, 64'd1);
    push_exp(16'h0000, 16'h0000, 7'b1000000); tick("beqz_exmem");
    clr(); MemWrite_IDEX = 1; A_IDEX = 16'h0001; B_IDEX = 16'h0002; BrType_IDEX = 3'd5;
    #1 chk("tb_off_in_squash", {63'd0, takeBranch}, 64'd0);
    push_exp(16'h0003, 16'h0002, 7'b0000000); tick("store_squashed");

    // Branch-type table, evaluated combinationally with EX/MEM frozen
    for (int i = 0; i < 6; i++) begin
      clr(); freeze = 1'b0; A_IDEX = br_a[i]; BrType_IDEX = br_t[i];
      #1 chk($sformatf("br_type_%0d", i), {63'd0, takeBranch}, {63'd0, br_e[i]});
    end

    // JAL, then squash held across three frozen cycles
    clr(); BrType_IDEX = 3'd5; LinkSel_IDEX = 1; PCinc_IDEX = 16'h0022; BrTarget_IDEX = 16'h0100;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd1;
    push_exp(16'h0022, 16'h0000, 7'b1000100); tick("jal");
    for (int i = 0; i < 3; i++) begin
      clr(); freeze = 1'b0; A_IDEX = 16'h5555; RegWrite_IDEX = 1; BrType_IDEX = 3'd5;
      #1 chk($sformatf("hold_tb_%0d", i), {63'd0, takeBranch}, 64'd0);
      exp_q.push_back(last_exp); tick($sformatf("hold_%0d", i));
    end
    clr(); A_IDEX = 16'h0001; B_IDEX = 16'h0001; RegWrite_IDEX = 1; WrR_IDEX = 3'd6;
    push_exp(16'h0002, 16'h0001, 7'b0000000); tick("squash_after_hold");
    clr(); A_IDEX = 16'h0002; B_IDEX = 16'h0002; RegWrite_IDEX = 1; WrR_IDEX = 3'd6;
    push_exp(16'h0004, 16'h0002, 7'b0000100); tick("pass_after_squash");

    // Every ALU op against the reference model
    for (int i = 0; i < 16; i++) begin
      clr();
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i == 8) rb = ra;
      ALUOp_IDEX = 4'(i); A_IDEX = ra; Dump_IDEX = (i == 14);
      if (i % 2 == 1) begin
        ImmSel_IDEX = 1; Imm_IDEX = rb; B_IDEX = 16'($urandom_range(0, 65535));
      end else begin
        B_IDEX = rb;
      end
      push_exp(alu_model(4'(i), ra, rb), B_IDEX, {5'b0, (i == 14), 1'b0});
      tick($sformatf("alu_op_%0d", i));
    end

    // Halt: halting instruction loads, later ones lose control bits
    clr(); A_IDEX = 16'h0001; B_IDEX = 16'h0001; halt_IDEX = 1; RegWrite_IDEX = 1; WrR_IDEX = 3'd6;
    push_exp(16'h0002, 16'h0001, 7'b0000101); tick("halt_load");
    clr(); A_IDEX = 16'h0003; B_IDEX = 16'h0004; RegWrite_IDEX = 1; MemWrite_IDEX = 1;
    BrType_IDEX = 3'd5; WrR_IDEX = 3'd2;
    #1 chk("tb_off_halted", {63'd0, takeBranch}, 64'd0);
    push_exp(16'h0007, 16'h0004, 7'b0000001); tick("after_halt");

    // Simultaneous branch and halt, then reset mid-squash
    rst = 1'b1; #1 rst = 1'b0;
    clr(); A_IDEX = 16'h0004; B_IDEX = 16'h0004; halt_IDEX = 1; BrType_IDEX = 3'd5;
    RegWrite_IDEX = 1; WrR_IDEX = 3'd7; BrTarget_IDEX = 16'h0200;
    #1 chk("br_halt_tb", {63'd0, takeBranch}, 64'd1);
    push_exp(16'h0008, 16'h0004, 7'b1000101); tick("br_and_halt");
    clr(); freeze = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_exmem", {6'd0, act}, 64'd0);
    chk("rst_mid_tb", {63'd0, takeBranch}, 64'd0);
    BrType_IDEX = 3'd5;
    #1 chk("rst_tb_req", {63'd0, takeBranch}, 64'd1);
    rst = 1'b0;
    clr(); A_IDEX = 16'h0001; B_IDEX = 16'h0002; RegWrite_IDEX = 1; WrR_IDEX = 3'd3;
    push_exp(16'h0003, 16'h0002, 7'b0000100); tick("resume_1");
    clr(); A_IDEX = 16'h0010; B_IDEX = 16'h0020; RegWrite_IDEX = 1; MemWrite_IDEX = 1; WrR_IDEX = 3'd4;
    push_exp(16'h0030, 16'h0020, 7'b0100100); tick("resume_2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
